wta_rank_logger: RTL and testbench
==================================

Name: wta_rank_logger

Overview:
- Downstream consumer of the per-channel PWM falling-edge pulses from the PWM sync stage.
- Timestamps each channel's first fall within a frame and assigns a dense arrival rank (winner-take-all order).
- Queues {rank, channel, timestamp} records into a show-ahead FIFO drained by a valid/ready read port, for readout through the SPI readback path.
- Also produces a live K-winner mask and frame status flags.

Parameters:
- N_CH, 8, number of channels; rank and channel fields are 3 bits wide (fixed for 8).
- TS_W, 12, timestamp/timer width, matching the 12-bit PWM counts.
- FIFO_DEPTH, 8, record FIFO depth; power of two, minimum 2.
- T_MAX, 4095, frame timeout in cycles; must be ≤ 2^TS_W − 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  frame start pulse (the PWM trigger)
- i_fall  in  N_CH  one-cycle falling-edge pulses per channel
- i_k  in  3  winner count select; K = i_k + 1 (range 1..8)
- i_rd_ready  in  1  consumer accepts the record at the FIFO head
- o_rd_valid  out  1  FIFO non-empty
- o_rd_data  out  3+3+TS_W  {rank[2:0], channel[2:0], timestamp[TS_W-1:0]}
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored records
- o_winner_mask  out  N_CH  channels with rank < K
- o_seen_count  out  4  channels captured this frame
- o_busy  out  1  state is ARMED or DRAIN
- o_done  out  1  state is DONE
- o_timeout  out  1  latched when the frame ends by timeout

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; timer = 0; seen, pending, winner mask, seen count = 0.
  - FIFO emptied; o_rd_valid = 0; o_rd_data = 0; all flags = 0.
  - Reset asserted mid-frame discards all records, including unread FIFO entries.
- States: IDLE, ARMED, DRAIN, DONE.
- i_start handling:
  - Accepted only in IDLE or DONE; ignored in ARMED and DRAIN.
  - On acceptance: timer = 0; seen, pending, winner mask, o_timeout cleared; next state ARMED.
  - The FIFO is NOT flushed; unread records from the previous frame stay ahead of new ones.
- ARMED:
  - Timer increments by 1 each cycle.
  - Capture set = i_fall & ~seen.
  - For each channel c in the capture set:
    - ts[c] = current timer value.
    - rank[c] = seen_count + (number of captured channels with index < c).
    - Set seen[c] and pending[c].
    - If rank[c] < K, set winner mask bit c.
  - Equal timestamps are tie-broken by lower channel index.
  - A repeat fall on a channel already in seen is ignored.
  - Falls arriving in IDLE, DRAIN or DONE are ignored.
- Leaving ARMED:
  - When seen becomes all-ones → DRAIN.
  - Else when timer == T_MAX−1 → DRAIN with o_timeout = 1. A fall in that same cycle is still captured.
- Drain (runs in ARMED and DRAIN):
  - A next_rank pointer is cleared at i_start.
  - Each cycle, if a pending channel has rank == next_rank and the FIFO is not full (or is being popped this cycle): push its record, clear its pending bit, increment next_rank.
  - At most one push per cycle, so FIFO order equals rank order.
  - A full FIFO stalls the drain; no record is dropped.
- DRAIN → DONE when pending == 0.
- Latency:
  - A fall sampled at edge e is written to the FIFO at edge e+1 at the earliest.
  - o_rd_valid is high after edge e+1, i.e. 2 cycles from the fall cycle.
  - Simultaneous falls then emerge one per cycle.
- FIFO:
  - Show-ahead; a pop occurs when o_rd_valid && i_rd_ready.
  - A simultaneous push and pop when full is allowed; level is unchanged.
  - A pop when empty is a no-op.
- i_k is sampled live; changing it mid-frame affects only later captures. The winner mask is not recomputed.

Test Plan:
- Staggered falls: i_start, then channels 3, 5, 0 fall at timer 10, 20, 30, i_rd_ready=1 → records {0,3,10}, {1,5,20}, {2,0,30}. With i_k=1, o_winner_mask = 0x28.
- Tie: channels 6, 2, 4 fall in the same cycle at timer 7 → records in order {0,2,7}, {1,4,7}, {2,6,7}, one per cycle. o_seen_count = 3.
- All eight channels fall with i_rd_ready=0 and FIFO_DEPTH=4 → o_fifo_level saturates at 4; pending holds the rest. Raising ready drains all 8 in rank order 0..7, then o_done = 1.
- Timeout: T_MAX=100; only channel 1 falls, at timer 50 → at timer 99 o_timeout=1, one record {0,1,50}, then DONE. A later i_fall pulse produces no record.
- Repeat and restart: channel 0 falls twice (the second fall is ignored). A second i_start during ARMED is ignored. After DONE a new i_start clears the mask, but the old unread record remains at the FIFO head.
- rst asserted mid-frame with 3 records queued → next cycle o_rd_valid=0, o_fifo_level=0, state IDLE, all flags 0.

Source files
------------

// File: rtl/wta_rank_logger.sv
`default_nettype none
//==============================================================================
// Module : wta_rank_logger
// Brief  : Winner-take-all arrival ranker for per-channel PWM falling edges.
//          Timestamps the first fall of each channel in a frame, assigns a
//          dense arrival rank (ties broken by lower channel index), keeps a
//          live K-winner mask and pushes {rank, channel, timestamp} records
//          in rank order into a show-ahead FIFO read through valid/ready.
// Rev    : 1.0  initial release
//==============================================================================
module wta_rank_logger #(
    parameter int N_CH       = 8,
    parameter int TS_W       = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int T_MAX      = 4095
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [N_CH-1:0]               i_fall,
    input  logic [2:0]                    i_k,
    input  logic                          i_rd_ready,
    output logic                          o_rd_valid,
    output logic [6+TS_W-1:0]             o_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [N_CH-1:0]               o_winner_mask,
    output logic [3:0]                    o_seen_count,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_timeout
);

    localparam int              c_CH_W  = 3;
    localparam int              c_REC_W = 2 * c_CH_W + TS_W;
    localparam int              c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [TS_W-1:0] c_T_LAST = TS_W'(T_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------------
    state_t              r_state_q;
    logic [TS_W-1:0]     r_timer_q;
    logic [N_CH-1:0]     r_seen_q;
    logic [N_CH-1:0]     r_pending_q;
    logic [N_CH-1:0]     r_mask_q;
    logic [3:0]          r_count_q;
    logic [3:0]          r_next_rank_q;   // one extra bit so it can step past rank 7
    logic                r_timeout_q;
    logic [TS_W-1:0]     r_ts_q   [N_CH];
    logic [c_CH_W-1:0]   r_rank_q [N_CH];

    logic [c_REC_W-1:0]  r_mem_q  [FIFO_DEPTH];
    logic [c_AW:0]       r_wr_ptr_q;
    logic [c_AW:0]       r_rd_ptr_q;

    // ---------------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------------
    logic                w_armed;
    logic                w_drain_en;
    logic                w_start_ok;
    logic [N_CH-1:0]     w_capture;
    logic [3:0]          w_new_rank [N_CH];
    logic [3:0]          w_count_d;
    logic [3:0]          w_k_plus1;
    logic [N_CH-1:0]     w_win;
    logic [N_CH-1:0]     w_match;
    logic [c_CH_W-1:0]   w_sel_ch;
    logic                w_has_match;
    logic [c_AW:0]       w_level;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic [c_REC_W-1:0]  w_rec;
    logic [N_CH-1:0]     w_seen_d;
    logic [N_CH-1:0]     w_pending_d;

    assign w_armed    = (r_state_q == ST_ARMED);
    assign w_drain_en = (r_state_q == ST_ARMED) || (r_state_q == ST_DRAIN);
    assign w_start_ok = i_start && ((r_state_q == ST_IDLE) || (r_state_q == ST_DONE));

    // Only the first fall of each channel counts, and only while armed.
    assign w_capture  = w_armed ? (i_fall & ~r_seen_q) : '0;
    assign w_k_plus1  = {1'b0, i_k} + 4'd1;

    // Dense ranks: running count of earlier captures this cycle on top of the frame count.
    always_comb begin
        w_count_d = r_count_q;
        w_win     = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_new_rank[c] = w_count_d;
            w_win[c]      = w_capture[c] && (w_count_d < w_k_plus1);
            if (w_capture[c]) begin
                w_count_d = w_count_d + 4'd1;
            end
        end
    end

    // Find the pending channel whose rank is next to be logged (ranks are unique).
    always_comb begin
        w_match  = '0;
        w_sel_ch = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_pending_q[c] && ({1'b0, r_rank_q[c]} == r_next_rank_q)) begin
                w_match[c] = 1'b1;
                w_sel_ch   = c_CH_W'(c);
            end
        end
    end

    assign w_has_match = w_drain_en && (|w_match);

    assign w_level = r_wr_ptr_q - r_rd_ptr_q;
    assign w_full  = (w_level == (c_AW + 1)'(FIFO_DEPTH));
    assign w_empty = (w_level == '0);
    assign w_pop   = !w_empty && i_rd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = w_has_match && (!w_full || w_pop);
    assign w_rec   = {r_rank_q[w_sel_ch], w_sel_ch, r_ts_q[w_sel_ch]};

    assign w_seen_d    = r_seen_q | w_capture;
    assign w_pending_d = (r_pending_q & ~(w_push ? w_match : '0)) | w_capture;

    // Frame control FSM with timer, seen/pending sets, winner mask and drain pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_timer_q     <= '0;
            r_seen_q      <= '0;
            r_pending_q   <= '0;
            r_mask_q      <= '0;
            r_count_q     <= '0;
            r_next_rank_q <= '0;
            r_timeout_q   <= 1'b0;
        end else if (w_start_ok) begin
            r_state_q     <= ST_ARMED;
            r_timer_q     <= '0;
            r_seen_q      <= '0;
            r_pending_q   <= '0;
            r_mask_q      <= '0;
            r_count_q     <= '0;
            r_next_rank_q <= '0;
            r_timeout_q   <= 1'b0;
        end else begin
            case (r_state_q)
                ST_ARMED: begin
                    r_timer_q   <= r_timer_q + TS_W'(1);
                    r_seen_q    <= w_seen_d;
                    r_pending_q <= w_pending_d;
                    r_count_q   <= w_count_d;
                    r_mask_q    <= r_mask_q | w_win;
                    // A full set wins over a timeout landing in the same cycle.
                    if (&w_seen_d) begin
                        r_state_q <= ST_DRAIN;
                    end else if (r_timer_q == c_T_LAST) begin
                        r_state_q   <= ST_DRAIN;
                        r_timeout_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_pending_q <= w_pending_d;
                    if (r_pending_q == '0) begin
                        r_state_q <= ST_DONE;
                    end
                end
                default: begin
                end
            endcase
            if (w_push) begin
                r_next_rank_q <= r_next_rank_q + 4'd1;
            end
        end
    end

    // Per-channel timestamp and rank latched on the capturing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_ts_q[c]   <= '0;
                r_rank_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_capture[c]) begin
                    r_ts_q[c]   <= r_timer_q;
                    r_rank_q[c] <= w_new_rank[c][c_CH_W-1:0];
                end
            end
        end
    end

    // FIFO pointers; reset empties the queue including unread records.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr_q <= r_wr_ptr_q + (c_AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr_q <= r_rd_ptr_q + (c_AW + 1)'(1);
            end
        end
    end

    // FIFO storage, written without reset so it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_q[r_wr_ptr_q[c_AW-1:0]] <= w_rec;
        end
    end

    assign o_rd_valid    = !w_empty;
    assign o_rd_data     = w_empty ? '0 : r_mem_q[r_rd_ptr_q[c_AW-1:0]];
    assign o_fifo_level  = w_level;
    assign o_winner_mask = r_mask_q;
    assign o_seen_count  = r_count_q;
    assign o_busy        = w_drain_en;
    assign o_done        = (r_state_q == ST_DONE);
    assign o_timeout     = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_wta_rank_logger.sv
`default_nettype none
//==============================================================================
// Module : tb_wta_rank_logger
// Brief  : Self-checking bench for wta_rank_logger: frame table plus random
//          frames against an ordering model, and hand sequences for latency,
//          restart and mid-frame reset.
// Rev    : 1.0  initial release
//==============================================================================
module tb_wta_rank_logger;

    localparam int         N_CH       = 8;
    localparam int         TS_W       = 12;
    localparam int         FIFO_DEPTH = 4;
    localparam int         T_MAX      = 100;
    localparam int         N_VEC      = 14;
    localparam logic [7:0] NO         = 8'd255;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_fall;
    logic [2:0]  i_k;
    logic        i_rd_ready;
    logic        o_rd_valid;
    logic [17:0] o_rd_data;
    logic [2:0]  o_fifo_level;
    logic [7:0]  o_winner_mask;
    logic [3:0]  o_seen_count;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;

    int          total = 0;
    int          bad   = 0;
    logic [17:0] exp_q [$];
    logic [17:0] m_exp;

    typedef struct packed {
        logic [7:0][7:0] t;     // fall cycle per channel, NO = never
        logic [2:0]      k;
        logic [1:0]      rdy;   // 0: held low in frame, 1: high, 2: random
        logic [7:0]      mask;
        logic [3:0]      cnt;
        logic            tmo;
    } vec_t;

    vec_t vecs [N_VEC];

    always #5 clk = ~clk;

    wta_rank_logger #(
        .N_CH       (N_CH),
        .TS_W       (TS_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .T_MAX      (T_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_fall        (i_fall),
        .i_k           (i_k),
        .i_rd_ready    (i_rd_ready),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .o_fifo_level  (o_fifo_level),
        .o_winner_mask (o_winner_mask),
        .o_seen_count  (o_seen_count),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout     (o_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Every accepted pop must match the next record the model predicts.
    always @(negedge clk) begin
        if (!rst && o_rd_valid === 1'b1 && i_rd_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop: got 0x%0h want no record", o_rd_data);
            end else begin
                m_exp = exp_q.pop_front();
                if (o_rd_data !== m_exp) begin
                    bad++;
                    $display("FAIL pop: got 0x%0h want 0x%0h", o_rd_data, m_exp);
                end
            end
        end
    end

    // Ordering model: channels sorted by (fall cycle, index) within the frame window.
    task automatic model(input vec_t v, input bit push, output logic [7:0] mask,
                         output logic [3:0] cnt, output logic tmo);
        int r;
        r    = 0;
        mask = '0;
        for (int tt = 0; tt < T_MAX; tt++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(v.t[c]) == tt) begin
                    if (r <= int'(v.k)) mask[c] = 1'b1;
                    if (push) exp_q.push_back({3'(r), 3'(c), 12'(tt)});
                    r++;
                end
            end
        end
        cnt = 4'(r);
        tmo = (r < N_CH);
    endtask

    task automatic wait_done(input string nm, input bit need_empty);
        int n;
        n = 0;
        while (!(o_done === 1'b1 && (!need_empty || exp_q.size() == 0)) && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL %s: wait expired, done=%0b queued=%0d want done=1", nm, o_done, exp_q.size());
        end
    endtask

    function automatic vec_t mk(input logic [63:0] times, input logic [2:0] k, input logic [1:0] rdy,
                                input logic [7:0] mask, input logic [3:0] cnt, input logic tmo);
        vec_t v;
        v.t    = times;
        v.k    = k;
        v.rdy  = rdy;
        v.mask = mask;
        v.cnt  = cnt;
        v.tmo  = tmo;
        return v;
    endfunction

    task automatic run_vec(input int idx);
        vec_t       v;
        logic [7:0] m;
        logic [3:0] n;
        logic       to;
        int         lim;
        v = vecs[idx];
        model(v, 1'b1, m, n, to);
        i_k        = v.k;
        i_rd_ready = (v.rdy == 2'd1);
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        for (int cyc = 0; cyc < T_MAX + 20; cyc++) begin
            for (int c = 0; c < N_CH; c++) i_fall[c] = (int'(v.t[c]) == cyc);
            if (v.rdy == 2'd2) i_rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        i_fall = '0;
        if (v.rdy == 2'd0) begin
            repeat (10) tick();
            lim = (int'(v.cnt) > FIFO_DEPTH) ? FIFO_DEPTH : int'(v.cnt);
            chk($sformatf("v%0d_level_full", idx), o_fifo_level, lim);
            chk($sformatf("v%0d_busy_stall", idx), o_busy, (int'(v.cnt) > FIFO_DEPTH));
        end
        i_rd_ready = 1'b1;
        wait_done($sformatf("v%0d_done", idx), 1'b1);
        chk($sformatf("v%0d_mask", idx), o_winner_mask, v.mask);
        chk($sformatf("v%0d_count", idx), o_seen_count, v.cnt);
        chk($sformatf("v%0d_timeout", idx), o_timeout, v.tmo);
        chk($sformatf("v%0d_level0", idx), o_fifo_level, 0);
        chk($sformatf("v%0d_busy0", idx), o_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        logic [3:0] n;
        logic       to;

        // Fixed frames: times listed as {ch7, ch6, ..., ch0}
        vecs[0] = mk({NO, NO, 8'd20, NO, 8'd10, NO, NO, 8'd30}, 3'd1, 2'd1, 8'h28, 4'd3, 1'b1);
        vecs[1] = mk({NO, 8'd7, NO, 8'd7, NO, 8'd7, NO, NO}, 3'd2, 2'd1, 8'h54, 4'd3, 1'b1);
        vecs[2] = mk({8'd12, 8'd9, 8'd33, 8'd1, 8'd40, 8'd5, 8'd5, 8'd20}, 3'd7, 2'd0, 8'hFF, 4'd8, 1'b0);
        vecs[3] = mk({NO, NO, NO, NO, NO, NO, 8'd50, NO}, 3'd0, 2'd1, 8'h02, 4'd1, 1'b1);
        vecs[4] = mk({8{8'd99}}, 3'd3, 2'd2, 8'h0F, 4'd8, 1'b0);
        vecs[5] = mk({8'd99, NO, NO, NO, NO, NO, NO, 8'd100}, 3'd0, 2'd1, 8'h80, 4'd1, 1'b1);
        for (int i = 6; i < N_VEC; i++) begin
            for (int c = 0; c < N_CH; c++)
                vecs[i].t[c] = ($urandom_range(0, 3) == 0) ? NO : 8'($urandom_range(0, 119));
            vecs[i].k   = 3'($urandom_range(0, 7));
            vecs[i].rdy = 2'($urandom_range(0, 2));
            model(vecs[i], 1'b0, m, n, to);
            vecs[i].mask = m;
            vecs[i].cnt  = n;
            vecs[i].tmo  = to;
        end

        rst        = 1'b1;
        i_start    = 1'b0;
        i_fall     = '0;
        i_k        = 3'd0;
        i_rd_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid", o_rd_valid, 0);
        chk("rst_data", o_rd_data, 0);
        chk("rst_level", o_fifo_level, 0);
        chk("rst_mask", o_winner_mask, 0);
        chk("rst_count", o_seen_count, 0);
        chk("rst_flags", {o_busy, o_done, o_timeout}, 0);

        for (int i = 0; i < N_VEC; i++) run_vec(i);

        // Latency: fall at timer 10 appears at the FIFO head two cycles later
        i_k = 3'd0; i_rd_ready = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (10) tick();
        i_fall = 8'h08; tick(); i_fall = '0;
        chk("lat_valid_e", o_rd_valid, 0);
        tick();
        chk("lat_valid_e1", o_rd_valid, 1);
        chk("lat_data", o_rd_data, {3'd0, 3'd3, 12'd10});
        chk("lat_level", o_fifo_level, 1);
        exp_q.push_back({3'd0, 3'd3, 12'd10});
        i_rd_ready = 1'b1;
        wait_done("lat_done", 1'b1);
        chk("lat_timeout", o_timeout, 1);
        chk("lat_mask", o_winner_mask, 8'h08);
        // A fall after the frame has ended is ignored
        i_fall = 8'h04; tick(); i_fall = '0;
        repeat (3) tick();
        chk("late_fall_valid", o_rd_valid, 0);
        chk("late_fall_count", o_seen_count, 1);

        // Repeat fall, ignored restart, and FIFO carry-over across frames
        i_rd_ready = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (5) tick();
        i_fall = 8'h01; tick(); i_fall = '0;
        repeat (2) tick();
        i_fall = 8'h01; tick(); i_fall = '0;
        tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick();
        i_fall = 8'h04; tick(); i_fall = '0;
        exp_q.push_back({3'd0, 3'd0, 12'd5});
        exp_q.push_back({3'd1, 3'd2, 12'd12});
        chk("rep_count", o_seen_count, 2);
        chk("rep_mask", o_winner_mask, 8'h01);
        wait_done("rep_done", 1'b0);
        chk("rep_level", o_fifo_level, 2);
        chk("rep_timeout", o_timeout, 1);
        i_start = 1'b1; tick(); i_start = 1'b0;
        chk("restart_mask", o_winner_mask, 0);
        chk("restart_count", o_seen_count, 0);
        chk("restart_flags", {o_busy, o_done, o_timeout}, 3'b100);
        chk("restart_head", o_rd_data, {3'd0, 3'd0, 12'd5});
        chk("restart_level", o_fifo_level, 2);
        i_rd_ready = 1'b1;
        wait_done("restart_done", 1'b1);

        // Reset mid-frame with three records queued
        i_rd_ready = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (3) tick();
        i_fall = 8'h0E; tick(); i_fall = '0;
        repeat (5) tick();
        chk("mid_level", o_fifo_level, 3);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", o_rd_valid, 0);
        chk("mid_rst_data", o_rd_data, 0);
        chk("mid_rst_level", o_fifo_level, 0);
        chk("mid_rst_mask", o_winner_mask, 0);
        chk("mid_rst_count", o_seen_count, 0);
        chk("mid_rst_flags", {o_busy, o_done, o_timeout}, 0);
        i_fall = 8'h01; tick(); i_fall = '0;
        tick();
        chk("idle_fall_count", o_seen_count, 0);
        chk("idle_fall_valid", o_rd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
